sro_update_engine: RTL and testbench
====================================

Name: sro_update_engine

Overview:
- Parametrised next-generation engine for stochastic random-order asynchronous (SRO) simulation of a Boolean regulatory network.
- Each round updates every element exactly once, in pseudo-random order, using an external combinational network-logic block.
- Supports knock-out and over-expression masks, a programmable round limit, steady-state detection and a start/done handshake.
- Sits between the top-level host interface and the network_logic instance.

Parameters:
- RULES, 32, number of network elements (2 to 1024).
- LOG_RULES, 5, index width; must satisfy 2**LOG_RULES >= RULES.
- ROUND_W, 10, width of the round counter and of max_rounds.
- MAX_RETRY, 8, consecutive rejected random picks before the deterministic fallback is used.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- abort  in  1  synchronous return to IDLE from any state
- seed  in  64  RNG seed, sampled on accepted start
- init_state  in  RULES  initial network state, sampled on accepted start
- ko_mask  in  RULES  knock-out mask (forces 0), sampled on accepted start
- oe_mask  in  RULES  over-expression mask (forces 1), sampled on accepted start
- max_rounds  in  ROUND_W  round limit, sampled on accepted start; 0 means 2**ROUND_W
- logic_output  in  RULES  next-state vector from network_logic, driven by network_state
- network_state  out  RULES  effective state: (state & ~ko) | (oe & ~ko)
- busy  out  1  high in LOAD, RUN or ROUND_END
- done  out  1  high in DONE
- steady_state  out  1  valid while done is high
- round_number  out  ROUND_W  count of completed rounds

Behaviour:
- Reset (rst=0, asynchronous) drives all outputs to 0, clears state, masks and the updated vector, sets the LFSR to 64'h1 and enters IDLE.
- States: IDLE, LOAD, RUN, ROUND_END, DONE.
- IDLE/DONE + start:
  - Register seed, masks, max_rounds and init_state; a seed of 0 is replaced by 64'h1.
  - Clear round_number, the updated vector, steady_state and done; go to LOAD.
- LOAD: copy the state into last_state; go to RUN. Latency from start to the first update is 2 cycles.
- RUN, one candidate per cycle:
  - The LFSR (64-bit Galois, taps 64,63,61,60) advances every RUN cycle; idx = lfsr[LOG_RULES-1:0].
  - Accept if idx < RULES and updated[idx] == 0. On accept: state[idx] <= effective logic_output[idx]; updated[idx] <= 1; retry count <= 0.
  - On reject: retry count increments. If the retry count equals MAX_RETRY-1, the same cycle uses the lowest-index non-updated element instead, so there are never more than MAX_RETRY cycles per update.
  - When the update sets the last 0 bit of updated, go to ROUND_END next cycle.
- ROUND_END, 1 cycle:
  - round_number increments, with modulo wrap.
  - If state == last_state: steady_state <= 1, go to DONE.
  - Else if the incremented round_number == max_rounds (mod 2**ROUND_W): steady_state <= 0, go to DONE.
  - Otherwise clear updated, last_state <= state, go to RUN.
- DONE: outputs hold; a new start restarts the run, and round_number is cleared in that same cycle.
- Knocked-out bits are always 0 in network_state; ko takes precedence over oe.
- Simultaneous start and abort: abort wins and the next state is IDLE.
- Abort keeps the state register and round_number but clears busy, done and updated.
- Mid-run reset returns to IDLE immediately.
- start while busy is ignored.

Optional Feature:
- Macro SRO_UPDATE_TRACE_EN.
- Defined: adds outputs trace_valid (1), trace_idx (LOG_RULES) and trace_val (1), registered. Each accepted update is reported the cycle after it is written. Exactly RULES pulses occur per round, and each index appears once per round.
- Undefined: the ports are absent and there is no trace logic. Core behaviour is identical.

Test Plan:
- RULES=4, logic_output = network_state (identity), init 4'b1010, seed 1 -> done after round 1, steady_state=1, round_number=1, network_state=4'b1010.
- RULES=4, logic_output = ~network_state, max_rounds=5 -> done with steady_state=0, round_number=5; no RUN stretch exceeds 4*MAX_RETRY cycles per round.
- RULES=5 (non-power-of-2), seed 64'hDEADBEEF -> every round updates indices 0..4 exactly once; indices 5..7 are never written (checked with trace when enabled).
- ko_mask=4'b0001, oe_mask=4'b0011, inverter network -> bit0 reads 0 and bit1 reads 1 in every cycle; bit0 of network_state never reads 1.
- abort in the 3rd RUN cycle, then start 2 cycles later with seed 0 -> IDLE on the cycle after abort; the restart behaves identically to a run with seed 64'h1.
- rst asserted mid-RUN, then released and start issued -> all outputs 0 during reset; the new run completes normally.

Source files
------------

// File: rtl/sro_update_engine_if.sv
// sro_update_engine_if: host/network bundle for the SRO update engine.
// master = host side (drives start/config/logic_output), slave = engine.
interface sro_update_engine_if #(
  parameter int RULES   = 32,
  parameter int ROUND_W = 10
`ifdef SRO_UPDATE_TRACE_EN
  , parameter int LOG_RULES = 5
`endif
);
  logic               start;
  logic               abort;
  logic [63:0]        seed;
  logic [RULES-1:0]   init_state;
  logic [RULES-1:0]   ko_mask;
  logic [RULES-1:0]   oe_mask;
  logic [ROUND_W-1:0] max_rounds;
  logic [RULES-1:0]   logic_output;
  logic [RULES-1:0]   network_state;
  logic               busy;
  logic               done;
  logic               steady_state;
  logic [ROUND_W-1:0] round_number;
`ifdef SRO_UPDATE_TRACE_EN
  logic                 trace_valid;
  logic [LOG_RULES-1:0] trace_idx;
  logic                 trace_val;

  modport master (
    output start, abort, seed, init_state, ko_mask, oe_mask,
    output max_rounds, logic_output,
    input  network_state, busy, done, steady_state, round_number,
    input  trace_valid, trace_idx, trace_val
  );
  modport slave (
    input  start, abort, seed, init_state, ko_mask, oe_mask,
    input  max_rounds, logic_output,
    output network_state, busy, done, steady_state, round_number,
    output trace_valid, trace_idx, trace_val
  );
`else
  modport master (
    output start, abort, seed, init_state, ko_mask, oe_mask,
    output max_rounds, logic_output,
    input  network_state, busy, done, steady_state, round_number
  );
  modport slave (
    input  start, abort, seed, init_state, ko_mask, oe_mask,
    input  max_rounds, logic_output,
    output network_state, busy, done, steady_state, round_number
  );
`endif
endinterface

// File: rtl/sro_update_engine.sv
// sro_update_engine: random-order asynchronous update engine for a
// Boolean network; every round updates each element exactly once.
// Ports: clk, rst (async active-low), bus (slave): start/abort/seed,
// init_state, ko_mask, oe_mask, max_rounds, logic_output in;
// network_state, busy, done, steady_state, round_number out.
// Optional trace outputs (trace_valid/idx/val) with SRO_UPDATE_TRACE_EN.
module sro_update_engine #(
  parameter int RULES     = 32,
  parameter int LOG_RULES = 5,
  parameter int ROUND_W   = 10,
  parameter int MAX_RETRY = 8
) (
  input  logic               clk,
  input  logic               rst,
  sro_update_engine_if.slave bus
);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, ROUND_END, DONE
  } st_e;

  st_e                st_q, st_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [RULES-1:0]   state_q, state_d;
  logic [RULES-1:0]   last_q, last_d;
  logic [RULES-1:0]   upd_q, upd_d;
  logic [RULES-1:0]   ko_q, ko_d;
  logic [RULES-1:0]   oe_q, oe_d;
  logic [ROUND_W-1:0] max_q, max_d;
  logic [ROUND_W-1:0] rnd_q, rnd_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               steady_q, steady_d;

  logic [2**LOG_RULES-1:0] upd_pad;
  logic [RULES-1:0]        eff_out;
  logic [LOG_RULES-1:0]    idx, sel;
  logic                    hit, fb, wr;
  logic [ROUND_W-1:0]      rnd_inc;

`ifdef SRO_UPDATE_TRACE_EN
  logic                 tv_q, tv_d;
  logic                 tval_q, tval_d;
  logic [LOG_RULES-1:0] ti_q, ti_d;
`endif

  always_comb begin
    eff_out = (bus.logic_output | oe_q) & ~ko_q;
    idx     = lfsr_q[LOG_RULES-1:0];
    // Indices beyond RULES look already-updated, so they always reject.
    upd_pad = '1;
    upd_pad[RULES-1:0] = upd_q;
    hit = !upd_pad[idx];
    fb  = 1'b0;
    sel = idx;
    if (!hit && retry_q == RETRY_LAST) begin
      fb = 1'b1;
      for (int i = RULES - 1; i >= 0; i--) begin
        if (!upd_q[i]) sel = LOG_RULES'(i);
      end
    end
    wr      = hit || fb;
    rnd_inc = rnd_q + ROUND_W'(1);

    st_d     = st_q;
    lfsr_d   = lfsr_q;
    state_d  = state_q;
    last_d   = last_q;
    upd_d    = upd_q;
    ko_d     = ko_q;
    oe_d     = oe_q;
    max_d    = max_q;
    rnd_d    = rnd_q;
    retry_d  = retry_q;
    busy_d   = busy_q;
    done_d   = done_q;
    steady_d = steady_q;
`ifdef SRO_UPDATE_TRACE_EN
    tv_d   = 1'b0;
    ti_d   = ti_q;
    tval_d = tval_q;
`endif

    unique case (st_q)
      IDLE, DONE: begin
        if (bus.start && !bus.abort) begin
          lfsr_d   = (bus.seed == '0) ? 64'h1 : bus.seed;
          state_d  = bus.init_state;
          ko_d     = bus.ko_mask;
          oe_d     = bus.oe_mask;
          max_d    = bus.max_rounds;
          rnd_d    = '0;
          upd_d    = '0;
          retry_d  = '0;
          steady_d = 1'b0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          st_d     = LOAD;
        end
      end
      LOAD: begin
        last_d = state_q;
        st_d   = RUN;
      end
      RUN: begin
        lfsr_d = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? TAPS : '0);
        if (wr) begin
          state_d[sel] = eff_out[sel];
          upd_d[sel]   = 1'b1;
          retry_d      = '0;
          if (&upd_d) st_d = ROUND_END;
`ifdef SRO_UPDATE_TRACE_EN
          tv_d   = 1'b1;
          ti_d   = sel;
          tval_d = eff_out[sel];
`endif
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      ROUND_END: begin
        rnd_d = rnd_inc;
        if (state_q == last_q) begin
          steady_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          st_d     = DONE;
        end else if (rnd_inc == max_q) begin
          steady_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          st_d     = DONE;
        end else begin
          upd_d  = '0;
          last_d = state_q;
          st_d   = RUN;
        end
      end
      default: st_d = IDLE;
    endcase

    if (bus.abort) begin
      st_d    = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      upd_d   = '0;
      retry_d = '0;
`ifdef SRO_UPDATE_TRACE_EN
      tv_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      lfsr_q   <= 64'h1;
      state_q  <= '0;
      last_q   <= '0;
      upd_q    <= '0;
      ko_q     <= '0;
      oe_q     <= '0;
      max_q    <= '0;
      rnd_q    <= '0;
      retry_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      steady_q <= 1'b0;
`ifdef SRO_UPDATE_TRACE_EN
      tv_q   <= 1'b0;
      ti_q   <= '0;
      tval_q <= 1'b0;
`endif
    end else begin
      st_q     <= st_d;
      lfsr_q   <= lfsr_d;
      state_q  <= state_d;
      last_q   <= last_d;
      upd_q    <= upd_d;
      ko_q     <= ko_d;
      oe_q     <= oe_d;
      max_q    <= max_d;
      rnd_q    <= rnd_d;
      retry_q  <= retry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      steady_q <= steady_d;
`ifdef SRO_UPDATE_TRACE_EN
      tv_q   <= tv_d;
      ti_q   <= ti_d;
      tval_q <= tval_d;
`endif
    end
  end

  assign bus.network_state = (state_q | oe_q) & ~ko_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.steady_state  = steady_q;
  assign bus.round_number  = rnd_q;
`ifdef SRO_UPDATE_TRACE_EN
  assign bus.trace_valid = tv_q;
  assign bus.trace_idx   = ti_q;
  assign bus.trace_val   = tval_q;
`endif
endmodule

// File: tb/tb_sro_update_engine.sv
// tb_sro_update_engine: randomized bench for two engine instances
// (RULES=4 and RULES=5) against a round-level reference model.
module tb_sro_update_engine;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam int MAX_RETRY = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tgt  = 0;
  int   mode = 0;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] seed  = '0;
  logic [7:0]  init  = '0;
  logic [7:0]  ko    = '0;
  logic [7:0]  oe    = '0;
  logic [9:0]  maxr  = '0;

  always #5 clk = ~clk;

  sro_update_engine_if #(.RULES(4), .ROUND_W(10)
`ifdef SRO_UPDATE_TRACE_EN
    , .LOG_RULES(2)
`endif
  ) b4 ();
  sro_update_engine_if #(.RULES(5), .ROUND_W(10)
`ifdef SRO_UPDATE_TRACE_EN
    , .LOG_RULES(3)
`endif
  ) b5 ();

  sro_update_engine #(.RULES(4), .LOG_RULES(2), .ROUND_W(10),
    .MAX_RETRY(MAX_RETRY)) u4 (.clk(clk), .rst(rst), .bus(b4));
  sro_update_engine #(.RULES(5), .LOG_RULES(3), .ROUND_W(10),
    .MAX_RETRY(MAX_RETRY)) u5 (.clk(clk), .rst(rst), .bus(b5));

  function automatic logic [7:0] netf(input logic [7:0] s,
                                      input int r, input int m);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < r; i++) begin
      case (m)
        0:       y[i] = s[i];
        1:       y[i] = ~s[i];
        default: y[i] = s[(i + 1) % r];
      endcase
    end
    return y;
  endfunction

  logic [7:0] lo4, lo5;
  assign lo4 = netf({4'b0, b4.network_state}, 4, mode);
  assign lo5 = netf({3'b0, b5.network_state}, 5, mode);

  assign b4.start        = start & (tgt == 0);
  assign b4.abort        = abort & (tgt == 0);
  assign b4.seed         = seed;
  assign b4.init_state   = init[3:0];
  assign b4.ko_mask      = ko[3:0];
  assign b4.oe_mask      = oe[3:0];
  assign b4.max_rounds   = maxr;
  assign b4.logic_output = lo4[3:0];

  assign b5.start        = start & (tgt == 1);
  assign b5.abort        = abort & (tgt == 1);
  assign b5.seed         = seed;
  assign b5.init_state   = init[4:0];
  assign b5.ko_mask      = ko[4:0];
  assign b5.oe_mask      = oe[4:0];
  assign b5.max_rounds   = maxr;
  assign b5.logic_output = lo5[4:0];

  logic [7:0] ns_o;
  logic [9:0] rn_o;
  logic       busy_o, done_o, st_o;
  assign ns_o   = (tgt == 0) ? {4'b0, b4.network_state} : {3'b0, b5.network_state};
  assign rn_o   = (tgt == 0) ? b4.round_number : b5.round_number;
  assign busy_o = (tgt == 0) ? b4.busy : b5.busy;
  assign done_o = (tgt == 0) ? b4.done : b5.done;
  assign st_o   = (tgt == 0) ? b4.steady_state : b5.steady_state;
`ifdef SRO_UPDATE_TRACE_EN
  logic       tv_o;
  logic [2:0] ti_o;
  assign tv_o = (tgt == 0) ? b4.trace_valid : b5.trace_valid;
  assign ti_o = (tgt == 0) ? {1'b0, b4.trace_idx} : b5.trace_idx;
`endif

  // Reference: rounds of random-order updates; cycle count includes LOAD
  // and one ROUND_END cycle per round.
  task automatic model(input int r, input int lr, input logic [63:0] sd,
                       input logic [7:0] in, input logic [7:0] k,
                       input logic [7:0] o, input int mr, input int m,
                       output logic [7:0] fin, output int rnds,
                       output bit stdy, output int cyc);
    logic [63:0] lf;
    logic [7:0]  st, prev, lo;
    bit          upd[8];
    int          left, retry, idx, pick, lim;
    lf = (sd == 0) ? 64'h1 : sd;
    st = in;
    rnds = 0;
    cyc = 1;
    retry = 0;
    stdy = 0;
    lim = (mr == 0) ? 1024 : mr;
    forever begin
      prev = st;
      for (int i = 0; i < 8; i++) upd[i] = 0;
      left = r;
      while (left > 0) begin
        idx = int'(lf & ((64'd1 << lr) - 64'd1));
        lf = lf[0] ? ((lf >> 1) ^ TAPS) : (lf >> 1);
        cyc++;
        pick = -1;
        if (idx < r && !upd[idx]) pick = idx;
        else if (retry == MAX_RETRY - 1)
          for (int i = r - 1; i >= 0; i--) if (!upd[i]) pick = i;
        if (pick >= 0) begin
          lo = netf((st | o) & ~k, r, m);
          st[pick] = (lo[pick] | o[pick]) & ~k[pick];
          upd[pick] = 1;
          left--;
          retry = 0;
        end else begin
          retry++;
        end
      end
      rnds++;
      cyc++;
      if (st == prev) begin stdy = 1; break; end
      if (rnds == lim) begin stdy = 0; break; end
    end
    fin = (st | o) & ~k;
  endtask

  task automatic go(input int t, input int m, input logic [63:0] sd,
                    input logic [7:0] in, input logic [7:0] k,
                    input logic [7:0] o, input int mr, input int poke,
                    output logic [7:0] fin, output int rnds,
                    output bit stdy, output int cyc, output int maxgap,
                    output int viol, output int terr, output bit tout);
    int         r, lastchg, gap;
    int         seen[8];
    logic [9:0] lastrn;
    logic [7:0] rm;
    r = (t == 0) ? 4 : 5;
    rm = 8'((1 << r) - 1);
    tgt = t; mode = m; seed = sd;
    init = in & rm; ko = k & rm; oe = o & rm; maxr = 10'(mr);
    for (int i = 0; i < 8; i++) seen[i] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; maxgap = 0; viol = 0; terr = 0; lastchg = 0; lastrn = '0;
    while (done_o !== 1'b1 && cyc < 60000) begin
      if (cyc == poke) begin start = 1'b1; seed = ~sd; end
      @(posedge clk); #1;
      start = 1'b0;
      seed = sd;
      cyc++;
      if ((ns_o & ko) != 0 || (ns_o & oe & ~ko) != (oe & ~ko)) viol++;
`ifdef SRO_UPDATE_TRACE_EN
      if (tv_o === 1'b1) begin
        if (int'(ti_o) < r) seen[ti_o]++;
        else terr++;
      end
`endif
      if (rn_o !== lastrn) begin
        gap = cyc - lastchg - ((lastchg == 0) ? 1 : 0);
        if (gap > maxgap) maxgap = gap;
        lastchg = cyc;
        lastrn = rn_o;
`ifdef SRO_UPDATE_TRACE_EN
        for (int i = 0; i < r; i++) begin
          if (seen[i] != 1) terr++;
          seen[i] = 0;
        end
`endif
      end
    end
    tout = (done_o !== 1'b1);
    fin = ns_o;
    rnds = int'(rn_o);
    stdy = st_o;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      #1;
      checks++;
      if ({ns_o, rn_o, busy_o, done_o, st_o} !== '0) begin
        errors++;
        $display("FAIL reset_outs dut%0d got ns=%h rn=%0d b=%b d=%b s=%b want all 0",
                 t, ns_o, rn_o, busy_o, done_o, st_o);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [7:0] fin, mfin;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    go(0, 0, 64'h1, 8'b1010, 0, 0, 0, -1, fin, rn, sd, cyc, gap, viol, terr, tout);
    model(4, 2, 64'h1, 8'b1010, 0, 0, 0, 0, mfin, mrn, msd, mcyc);
    checks++; if (tout) begin errors++; $display("FAIL id_timeout got busy want done"); end
    checks++; if (sd !== 1'b1) begin errors++; $display("FAIL id_steady got %b want 1", sd); end
    checks++; if (rn !== 1) begin errors++; $display("FAIL id_round got %0d want 1", rn); end
    checks++; if (fin !== 8'b1010) begin errors++; $display("FAIL id_state got %b want 1010", fin); end
    checks++; if (cyc !== mcyc) begin errors++; $display("FAIL id_cycles got %0d want %0d", cyc, mcyc); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL id_busy got %b want 0", busy_o); end
  endtask

  task automatic test_inverter();
    logic [7:0] fin, mfin;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    go(0, 1, 64'h1234_5678_9ABC_DEF1, 8'b1010, 0, 0, 5, -1,
       fin, rn, sd, cyc, gap, viol, terr, tout);
    model(4, 2, 64'h1234_5678_9ABC_DEF1, 8'b1010, 0, 0, 5, 1, mfin, mrn, msd, mcyc);
    checks++; if (tout) begin errors++; $display("FAIL inv_timeout got busy want done"); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL inv_steady got %b want 0", sd); end
    checks++; if (rn !== 5) begin errors++; $display("FAIL inv_round got %0d want 5", rn); end
    checks++; if (fin !== 8'b0101) begin errors++; $display("FAIL inv_state got %b want 0101", fin); end
    checks++; if (cyc !== mcyc) begin errors++; $display("FAIL inv_cycles got %0d want %0d", cyc, mcyc); end
    checks++; if (gap > 4 * MAX_RETRY + 1) begin errors++; $display("FAIL inv_stretch got %0d want <= %0d", gap, 4 * MAX_RETRY + 1); end
  endtask

  task automatic test_nonpow2();
    logic [7:0] fin, mfin, in;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    in = 8'($urandom_range(0, 31));
    go(1, 2, 64'hDEADBEEF, in, 0, 0, 4, -1, fin, rn, sd, cyc, gap, viol, terr, tout);
    model(5, 3, 64'hDEADBEEF, in, 0, 0, 4, 2, mfin, mrn, msd, mcyc);
    checks++; if (tout) begin errors++; $display("FAIL np2_timeout got busy want done"); end
    checks++; if (fin !== mfin) begin errors++; $display("FAIL np2_state got %b want %b", fin, mfin); end
    checks++; if (rn !== mrn || sd !== msd) begin errors++; $display("FAIL np2_result got rn=%0d s=%b want rn=%0d s=%b", rn, sd, mrn, msd); end
    checks++; if (cyc !== mcyc) begin errors++; $display("FAIL np2_cycles got %0d want %0d", cyc, mcyc); end
    checks++; if (gap > 5 * MAX_RETRY + 1) begin errors++; $display("FAIL np2_stretch got %0d want <= %0d", gap, 5 * MAX_RETRY + 1); end
`ifdef SRO_UPDATE_TRACE_EN
    checks++; if (terr !== 0) begin errors++; $display("FAIL np2_trace got %0d bad rounds want 0", terr); end
`endif
  endtask

  task automatic test_masks();
    logic [7:0] fin, mfin, in;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    in = 8'($urandom_range(0, 15));
    go(0, 1, {$urandom, $urandom}, in, 8'b0001, 8'b0011, 4, -1,
       fin, rn, sd, cyc, gap, viol, terr, tout);
    checks++; if (viol !== 0) begin errors++; $display("FAIL mask_cycles got %0d bad cycles want 0", viol); end
    checks++; if (fin[1:0] !== 2'b10) begin errors++; $display("FAIL mask_bits got %b want 10", fin[1:0]); end
    checks++; if (rn !== 4 || sd !== 1'b0) begin errors++; $display("FAIL mask_result got rn=%0d s=%b want rn=4 s=0", rn, sd); end
    model(4, 2, 64'h1, in, 8'b0001, 8'b0011, 4, 1, mfin, mrn, msd, mcyc);
    checks++; if (fin !== mfin) begin errors++; $display("FAIL mask_state got %b want %b", fin, mfin); end
  endtask

  task automatic test_abort();
    logic [7:0] fin, mfin, in;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    in = 8'($urandom_range(0, 15));
    tgt = 0; mode = 2; seed = {$urandom, $urandom}; init = in;
    ko = '0; oe = '0; maxr = 10'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL abort_idle got b=%b d=%b want 0 0", busy_o, done_o); end
    checks++; if (rn_o !== 10'd0) begin errors++; $display("FAIL abort_round got %0d want 0", rn_o); end
    @(posedge clk); #1;
    go(0, 2, 64'h0, in, 0, 0, 6, -1, fin, rn, sd, cyc, gap, viol, terr, tout);
    model(4, 2, 64'h1, in, 0, 0, 6, 2, mfin, mrn, msd, mcyc);
    checks++; if (tout) begin errors++; $display("FAIL seed0_timeout got busy want done"); end
    checks++; if (fin !== mfin || rn !== mrn || sd !== msd) begin errors++; $display("FAIL seed0_result got %b/%0d/%b want %b/%0d/%b", fin, rn, sd, mfin, mrn, msd); end
    checks++; if (cyc !== mcyc) begin errors++; $display("FAIL seed0_cycles got %0d want %0d", cyc, mcyc); end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL start_abort got b=%b d=%b want 0 0", busy_o, done_o); end
  endtask

  task automatic test_midreset();
    logic [7:0] fin, mfin, in;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    tgt = 0; mode = 1; seed = 64'h55; init = 8'b1111;
    ko = '0; oe = 8'b0100; maxr = 10'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++; if ({ns_o, rn_o, busy_o, done_o, st_o} !== '0) begin errors++; $display("FAIL rst_async got ns=%h b=%b want all 0", ns_o, busy_o); end
    @(posedge clk); #1;
    checks++; if ({ns_o, rn_o, busy_o, done_o, st_o} !== '0) begin errors++; $display("FAIL rst_hold got ns=%h b=%b want all 0", ns_o, busy_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    in = 8'($urandom_range(0, 15));
    go(0, 2, 64'h77, in, 0, 0, 5, -1, fin, rn, sd, cyc, gap, viol, terr, tout);
    model(4, 2, 64'h77, in, 0, 0, 5, 2, mfin, mrn, msd, mcyc);
    checks++; if (tout || fin !== mfin || rn !== mrn || sd !== msd || cyc !== mcyc) begin errors++; $display("FAIL rst_rerun got %b/%0d/%b/%0d want %b/%0d/%b/%0d", fin, rn, sd, cyc, mfin, mrn, msd, mcyc); end
  endtask

  task automatic test_max_zero();
    logic [7:0] fin, mfin;
    int rn, mrn, cyc, mcyc, gap, viol, terr;
    bit sd, msd, tout;
    go(0, 1, 64'hC0FFEE, 8'b0110, 0, 0, 0, -1, fin, rn, sd, cyc, gap, viol, terr, tout);
    model(4, 2, 64'hC0FFEE, 8'b0110, 0, 0, 0, 1, mfin, mrn, msd, mcyc);
    checks++; if (tout) begin errors++; $display("FAIL max0_timeout got busy want done"); end
    checks++; if (rn !== 0 || sd !== 1'b0 || fin !== 8'b0110) begin errors++; $display("FAIL max0_result got rn=%0d s=%b ns=%b want 0 0 0110", rn, sd, fin); end
    checks++; if (cyc !== mcyc) begin errors++; $display("FAIL max0_cycles got %0d want %0d", cyc, mcyc); end
  endtask

  task automatic test_random();
    logic [7:0] fin, mfin, in, k, o;
    logic [63:0] s;
    int rn, mrn, cyc, mcyc, gap, viol, terr, t, r, m, mr, poke;
    bit sd, msd, tout;
    for (int it = 0; it < 12; it++) begin
      t = it % 2;
      r = (t == 0) ? 4 : 5;
      s = (it == 4) ? 64'h0 : {$urandom, $urandom};
      in = 8'($urandom & ((1 << r) - 1));
      k  = ($urandom_range(0, 2) == 0) ? 8'($urandom & ((1 << r) - 1)) : 8'h0;
      o  = ($urandom_range(0, 2) == 0) ? 8'($urandom & ((1 << r) - 1)) : 8'h0;
      m  = $urandom_range(0, 2);
      mr = $urandom_range(1, 6);
      poke = (it % 3 == 0) ? $urandom_range(0, 3) : -1;
      go(t, m, s, in, k, o, mr, poke, fin, rn, sd, cyc, gap, viol, terr, tout);
      model(r, (t == 0) ? 2 : 3, s, in, k, o, mr, m, mfin, mrn, msd, mcyc);
      checks++; if (tout) begin errors++; $display("FAIL rnd%0d_timeout got busy want done", it); end
      checks++; if (fin !== mfin || rn !== mrn || sd !== msd) begin errors++; $display("FAIL rnd%0d_result got %b/%0d/%b want %b/%0d/%b", it, fin, rn, sd, mfin, mrn, msd); end
      checks++; if (cyc !== mcyc) begin errors++; $display("FAIL rnd%0d_cycles got %0d want %0d", it, cyc, mcyc); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL rnd%0d_mask got %0d bad cycles want 0", it, viol); end
`ifdef SRO_UPDATE_TRACE_EN
      checks++; if (terr !== 0) begin errors++; $display("FAIL rnd%0d_trace got %0d bad rounds want 0", it, terr); end
`endif
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_identity();
    test_inverter();
    test_nonpow2();
    test_masks();
    test_abort();
    test_midreset();
    test_max_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
